// File: rtl/memory_slave.sv
`default_nettype none
// ============================================================================
// Module   : memory_slave
// Brief    : Single-port register-file slave with a one-cycle response strobe
//            and error flag. Optional stored-parity check: MEMORY_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module memory_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef MEMORY_PARITY_EN
  input  logic                  par_inj,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slv_rsp,
  output logic                  slv_err
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] c_mem_size = (ADDR_WIDTH+1)'(MEM_SIZE);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [0:MEM_SIZE-1];
`ifdef MEMORY_PARITY_EN
  logic                  r_par [0:MEM_SIZE-1];
`endif

  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;

  // Compare one bit wider than addr so MEM_SIZE == 2**ADDR_WIDTH still works.
  assign w_in_range = ({1'b0, addr} < c_mem_size);
  assign w_idx      = addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      rdata   <= '0;
      slv_rsp <= 1'b0;
      slv_err <= 1'b0;
      for (int i = 0; i < MEM_SIZE; i++) begin
        r_mem[i] <= '0;
`ifdef MEMORY_PARITY_EN
        r_par[i] <= 1'b0;
`endif
      end
    end else begin
      slv_rsp <= 1'b0;
      slv_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr || rd) begin
            r_state <= S_RESP;
            slv_rsp <= 1'b1;
            if (wr && rd) begin
              slv_err <= 1'b1;
            end else if (!w_in_range) begin
              slv_err <= 1'b1;
              if (rd) rdata <= '0;
            end else if (wr) begin
              r_mem[w_idx] <= wdata;
`ifdef MEMORY_PARITY_EN
              r_par[w_idx] <= (^wdata) ^ par_inj;
`endif
            end else begin
              rdata <= r_mem[w_idx];
`ifdef MEMORY_PARITY_EN
              // Stored data is still returned; the mismatch only raises the flag.
              slv_err <= (^r_mem[w_idx]) ^ r_par[w_idx];
`endif
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_slave
// Brief    : Self-checking bench for memory_slave (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        par_inj = 1'b0;
  logic [31:0] rdata;
  logic        slv_rsp;
  logic        slv_err;

  memory_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .wdata   (wdata),
`ifdef MEMORY_PARITY_EN
    .par_inj (par_inj),
`endif
    .rdata   (rdata),
    .slv_rsp (slv_rsp),
    .slv_err (slv_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: every response strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && slv_rsp) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got slv_rsp=1, expected no response");
      end else begin
        e = sb.pop_front();
        check({e.name, "_err"}, {31'd0, slv_err}, {31'd0, e.err});
        check({e.name, "_rdata"}, rdata, e.rdata);
      end
    end
  end

  task automatic do_req(input logic w, input logic r, input logic [7:0] a,
                        input logic [31:0] d, input logic pi,
                        input logic e_err, input logic [31:0] e_rd, input string nm);
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = d; par_inj = pi;
    @(posedge clk);
    #1;
    sb.push_back('{e_err, e_rd, nm});
    wr = 1'b0; rd = 1'b0; par_inj = 1'b0;
    @(posedge clk);
  endtask

  vec_t vecs[12];
  int   p0;
  logic [31:0] exp_rd;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'd3,   32'hDEADBEEF, 1'b0, 32'h0,        "t1_wr3"};
    vecs[1]  = '{1'b0, 1'b1, 8'd3,   32'h0,        1'b0, 32'hDEADBEEF, "t1_rd3"};
    vecs[2]  = '{1'b1, 1'b0, 8'd16,  32'h12345678, 1'b1, 32'hDEADBEEF, "t2_wr16"};
    vecs[3]  = '{1'b0, 1'b1, 8'd16,  32'h0,        1'b1, 32'h0,        "t2_rd16"};
    vecs[4]  = '{1'b0, 1'b1, 8'd15,  32'h0,        1'b0, 32'h0,        "t2_rd15"};
    vecs[5]  = '{1'b1, 1'b0, 8'd255, 32'hCAFEF00D, 1'b1, 32'h0,        "t2_wr255"};
    vecs[6]  = '{1'b0, 1'b1, 8'd3,   32'h0,        1'b0, 32'hDEADBEEF, "t2_rd3"};
    vecs[7]  = '{1'b0, 1'b1, 8'd255, 32'h0,        1'b1, 32'h0,        "t2_rd255"};
    vecs[8]  = '{1'b1, 1'b0, 8'd15,  32'h0BADC0DE, 1'b0, 32'h0,        "t2_wr15"};
    vecs[9]  = '{1'b0, 1'b1, 8'd15,  32'h0,        1'b0, 32'h0BADC0DE, "t2_rd15b"};
    vecs[10] = '{1'b1, 1'b1, 8'd3,   32'h00000000, 1'b1, 32'h0BADC0DE, "t3_wrrd"};
    vecs[11] = '{1'b1, 1'b1, 8'd20,  32'h11111111, 1'b1, 32'h0BADC0DE, "t3_wrrd_oor"};

    repeat (2) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rsp", {31'd0, slv_rsp}, 32'h0);
    check("reset_err", {31'd0, slv_err}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      do_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b0,
             vecs[i].err, vecs[i].rdata, vecs[i].name);

    // T3: read held high across the RESP cycle yields exactly one response.
    p0 = pulses;
    @(negedge clk);
    rd = 1'b1; addr = 8'd3;
    @(posedge clk);
    #1;
    sb.push_back('{1'b0, 32'hDEADBEEF, "t3_held_rd"});
    @(posedge clk);
    #1;
    rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_held_pulses", pulses - p0, 32'd1);

    // T4: reset dropped during the response cycle.
    @(negedge clk);
    wr = 1'b1; addr = 8'd5; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    wr = 1'b0;
    check("t4_rsp_high", {31'd0, slv_rsp}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t4_rsp_async_drop", {31'd0, slv_rsp}, 32'h0);
    check("t4_rdata_cleared", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, 1'b1, 8'd5, 32'h0, 1'b0, 1'b0, 32'h0, "t4_rd5");

    // T5: sweep all words.
    p0 = pulses;
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 1'b0, 8'(i), ~32'(i), 1'b0, 1'b0, 32'h0, "t5_wr");
    for (int i = 0; i < 16; i++) begin
      exp_rd = ~32'(i);
      do_req(1'b0, 1'b1, 8'(i), 32'h0, 1'b0, 1'b0, exp_rd, "t5_rd");
    end
    repeat (2) @(posedge clk);
    #1;
    check("t5_pulses", pulses - p0, 32'd32);

`ifdef MEMORY_PARITY_EN
    do_req(1'b1, 1'b0, 8'd7, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFF0, "t6_wr_inj");
    do_req(1'b0, 1'b1, 8'd7, 32'h0,        1'b0, 1'b1, 32'h00000001, "t6_rd_bad");
    do_req(1'b1, 1'b0, 8'd7, 32'h00000001, 1'b0, 1'b0, 32'h00000001, "t6_wr_ok");
    do_req(1'b0, 1'b1, 8'd7, 32'h0,        1'b0, 1'b0, 32'h00000001, "t6_rd_ok");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
